seq_bit_serializer: RTL and testbench

//  Parallel-in/serial-out stage directly upstream of the Moore sequence detector.
//  - Accepts WIDTH-bit words over a valid/ready handshake.
//  - Emits them one bit per enabled clock on serial_out, which drives the detector's data_in.
//  - A one-entry pending buffer lets back-to-back words stream with no bubble between them.

---
 rtl/seq_serializer_pkg.sv | 14 +
 rtl/seq_bit_serializer_if.sv | 40 ++++
 rtl/seq_serializer_hold_buf.sv | 60 ++++++
 rtl/seq_bit_serializer.sv | 107 ++++++++++
 tb/tb_seq_bit_serializer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_serializer_pkg.sv
// Shared definitions for the bit serializer.
// Holds the FSM state encodings and the width of the state field. The top
// level and the bus interface both import this package.
package seq_serializer_pkg;

    localparam int STATE_W = 2;

    typedef logic [STATE_W-1:0] state_t;

    // Encodings 2'b10 and 2'b11 are unused; the FSM steers them back to IDLE.
    localparam logic [STATE_W-1:0] ST_IDLE  = 2'b00;
    localparam logic [STATE_W-1:0] ST_SHIFT = 2'b01;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Bus bundle between the word producer / serial consumer and the serializer.
// Signals:
//   load_data    producer -> serializer  parallel word
//   load_valid   producer -> serializer  load_data is valid
//   load_ready   serializer -> producer  pending buffer can accept a word
//   shift_en     consumer -> serializer  advance the stream by one bit
//   serial_out   serializer -> consumer  current bit
//   serial_valid serializer -> consumer  serial_out holds a data bit
//   word_done    serializer -> consumer  last bit of a word consumed this cycle
//   state        serializer -> trace     FSM state
//   bit_idx      serializer -> trace     index of the bit being presented
// Modports: master = producer/consumer side, slave = serializer side.
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
);
    import seq_serializer_pkg::*;

    localparam int IDX_W = $clog2(WIDTH);

    logic [WIDTH-1:0]   load_data;
    logic               load_valid;
    logic               load_ready;
    logic               shift_en;
    logic               serial_out;
    logic               serial_valid;
    logic               word_done;
    logic [STATE_W-1:0] state;
    logic [IDX_W-1:0]   bit_idx;

    modport master (
        output load_data, load_valid, shift_en,
        input  load_ready, serial_out, serial_valid, word_done, state, bit_idx
    );

    modport slave (
        input  load_data, load_valid, shift_en,
        output load_ready, serial_out, serial_valid, word_done, state, bit_idx
    );

endinterface

// File: rtl/seq_serializer_hold_buf.sv
// One-entry pending buffer in front of the serializer shift register.
// Ports:
//   clk, rst       clock and synchronous active-low reset
//   load_data_i    incoming parallel word
//   load_valid_i   incoming word valid
//   take_i         FSM moves the pending word into the shift register
//   pend_buf_o     buffered word
//   pend_full_o    buffer holds a word
//   load_ready_o   buffer can accept a word (registered, = !pend_full)
module seq_serializer_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             load_valid_i,
    input  logic             take_i,
    output logic [WIDTH-1:0] pend_buf_o,
    output logic             pend_full_o,
    output logic             load_ready_o
);

    logic [WIDTH-1:0] pend_buf_q;
    logic             pend_full_q;
    logic             pend_full_d;
    logic             accept;

    // Ready comes straight from the register, so a same-cycle take does not
    // open the buffer early; accept and take can therefore never coincide.
    assign accept = load_valid_i && !pend_full_q;

    always_comb begin
        pend_full_d = pend_full_q;
        if (accept) begin
            pend_full_d = 1'b1;
        end else if (take_i) begin
            pend_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_full_q <= 1'b0;
        end else begin
            pend_full_q <= pend_full_d;
        end
    end

    // Data path needs no reset: pend_full_q qualifies its contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_buf_q <= load_data_i;
        end
    end

    assign pend_buf_o   = pend_buf_q;
    assign pend_full_o  = pend_full_q;
    assign load_ready_o = !pend_full_q;

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-in / serial-out stage feeding the Moore sequence detector.
// Words arrive over a valid/ready handshake into a one-entry pending buffer
// and are shifted out one bit per shift_en cycle, back-to-back with no gap.
// Ports:
//   clk   clock, all state changes on posedge
//   rst   synchronous active-low reset
//   bus   seq_bit_serializer_if slave modport (handshake, serial stream, trace)
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
module seq_bit_serializer
    import seq_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_bit_serializer_if.slave   bus
);

    localparam int                IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   pend_buf;
    logic               pend_full;
    logic               take;
    logic               done;

    seq_serializer_hold_buf #(
        .WIDTH(WIDTH)
    ) u_hold_buf (
        .clk          (clk),
        .rst          (rst),
        .load_data_i  (bus.load_data),
        .load_valid_i (bus.load_valid),
        .take_i       (take),
        .pend_buf_o   (pend_buf),
        .pend_full_o  (pend_full),
        .load_ready_o (bus.load_ready)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        take    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pend_full) begin
                    shift_d = pend_buf;
                    idx_d   = '0;
                    take    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.shift_en) begin
                    if (idx_q == LAST_IDX) begin
                        done = 1'b1;
                        // Reload straight from the buffer so consecutive
                        // words stream without an idle bubble.
                        if (pend_full) begin
                            shift_d = pend_buf;
                            idx_d   = '0;
                            take    = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Vacated positions fill with zero.
                        shift_d = (MSB_FIRST != 0) ? {shift_q[WIDTH-2:0], 1'b0}
                                                   : {1'b0, shift_q[WIDTH-1:1]};
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
        end
    end

    assign bus.serial_valid = (state_q == ST_SHIFT);
    assign bus.serial_out   = bus.serial_valid &&
                              ((MSB_FIRST != 0) ? shift_q[WIDTH-1] : shift_q[0]);
    assign bus.word_done    = done;
    assign bus.state        = state_q;
    assign bus.bit_idx      = idx_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
module tb_seq_bit_serializer;
    import seq_serializer_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_bit_serializer_if #(.WIDTH(W)) if_m ();
    seq_bit_serializer_if #(.WIDTH(W)) if_l ();

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
        .clk (clk),
        .rst (rst),
        .bus (if_m.slave)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (if_l.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a word being emitted (with bits remaining) and a
    // queue of words waiting behind it.
    int             cur_left;
    logic [W-1:0]   cur_word;
    logic [W-1:0]   pend_q[$];

    // Observed stream capture.
    logic [31:0] cap_m;
    logic [31:0] cap_l;
    int          n_cap_l;
    int          n_valid;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_cap();
        cap_m   = '0;
        cap_l   = '0;
        n_cap_l = 0;
        n_valid = 0;
    endtask

    // Drive one cycle, compare outputs against the model, then advance the model at the edge.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic s, input logic r);
        int   pos;
        logic ev, em, el, ed;
        if_m.load_valid = v;  if_m.load_data = d;  if_m.shift_en = s;
        if_l.load_valid = v;  if_l.load_data = d;  if_l.shift_en = s;
        rst = r;
        #1;
        ev  = (cur_left > 0);
        pos = W - cur_left;
        em  = 1'b0;
        el  = 1'b0;
        if (ev) begin
            em = cur_word[W-1-pos];
            el = cur_word[pos];
        end
        ed = ev && s && (cur_left == 1);
        chk("m_valid", 32'(if_m.serial_valid), 32'(ev));
        chk("m_out",   32'(if_m.serial_out),   32'(em));
        chk("m_ready", 32'(if_m.load_ready),   32'(pend_q.size() == 0));
        chk("m_done",  32'(if_m.word_done),    32'(ed));
        chk("m_state", 32'(if_m.state),        32'(ev ? ST_SHIFT : ST_IDLE));
        if (ev) chk("m_idx", 32'(if_m.bit_idx), 32'(pos));
        chk("l_valid", 32'(if_l.serial_valid), 32'(ev));
        chk("l_out",   32'(if_l.serial_out),   32'(el));
        chk("l_done",  32'(if_l.word_done),    32'(ed));
        if (r) begin
            if (if_m.serial_valid) n_valid++;
            if (if_m.serial_valid && s) cap_m = {cap_m[30:0], if_m.serial_out};
            if (if_l.serial_valid && s && n_cap_l < 32) begin
                cap_l[n_cap_l] = if_l.serial_out;
                n_cap_l++;
            end
        end
        @(posedge clk);
        if (!r) begin
            cur_left = 0;
            pend_q.delete();
        end else begin
            logic acc;
            acc = v && (pend_q.size() == 0);
            if (cur_left > 0 && s) cur_left--;
            if (cur_left == 0 && pend_q.size() > 0) begin
                cur_word = pend_q.pop_front();
                cur_left = W;
            end
            if (acc) pend_q.push_back(d);
        end
        #1;
    endtask

    // Positions j (stream order) where bits j-3..j form 1101.
    function automatic logic [31:0] hit_mask(input logic [23:0] s);
        logic [31:0] m;
        m = '0;
        for (int j = 3; j < 24; j++) begin
            if ({s[26-j], s[25-j], s[24-j], s[23-j]} == 4'b1101) m[j] = 1'b1;
        end
        return m;
    endfunction

    initial begin
        int nload;
        logic [31:0] mk;
        rst = 1'b0;
        if_m.load_valid = 1'b0; if_m.load_data = '0; if_m.shift_en = 1'b0;
        if_l.load_valid = 1'b0; if_l.load_data = '0; if_l.shift_en = 1'b0;
        cur_left = 0;
        cur_word = '0;
        clr_cap();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_idx",   32'(if_m.bit_idx),      32'd0);
        chk("rst_valid", 32'(if_m.serial_valid), 32'd0);
        chk("rst_ready", 32'(if_m.load_ready),   32'd1);
        chk("rst_state", 32'(if_m.state),        32'(ST_IDLE));
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Single word
        clr_cap();
        cycle(1'b1, 8'hE7, 1'b1, 1'b1);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t1_stream", cap_m, 32'hE7);
        chk("t1_nvalid", 32'(n_valid), 32'd8);

        // Back-to-back
        clr_cap();
        cycle(1'b1, 8'hE7, 1'b1, 1'b1);
        cycle(1'b1, 8'h0F, 1'b1, 1'b1);
        cycle(1'b1, 8'h0F, 1'b1, 1'b1);
        repeat (20) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t2_stream", cap_m, 32'hE70F);
        chk("t2_nvalid", 32'(n_valid), 32'd16);

        // Stall after bit 3
        clr_cap();
        cycle(1'b1, 8'hA5, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1);
        repeat (3) cycle(1'b0, '0, 1'b0, 1'b1);
        chk("t3_idx", 32'(if_m.bit_idx), 32'd4);
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t3_stream", cap_m, 32'hA5);
        chk("t3_nvalid", 32'(n_valid), 32'd11);

        // Reset mid-word with a word pending
        cycle(1'b1, 8'hFF, 1'b1, 1'b1);
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        cycle(1'b1, 8'h00, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t4_idx_at_rst", 32'(if_m.bit_idx), 32'd5);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("t4_valid", 32'(if_m.serial_valid), 32'd0);
        chk("t4_ready", 32'(if_m.load_ready),   32'd1);
        chk("t4_state", 32'(if_m.state),        32'(ST_IDLE));
        clr_cap();
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t4_no_resume", 32'(n_valid), 32'd0);

        // LSB-first
        clr_cap();
        cycle(1'b1, 8'h01, 1'b1, 1'b1);
        repeat (12) cycle(1'b0, '0, 1'b1, 1'b1);
        chk("t5_lsb_stream", cap_l, 32'h01);
        chk("t5_lsb_nbits",  32'(n_cap_l), 32'd8);

        // Stream of 8'hEE words into a 1101 detector
        clr_cap();
        nload = 0;
        for (int i = 0; i < 40; i++) begin
            logic v;
            v = (nload < 3);
            if (v && if_m.load_ready) nload++;
            cycle(v, 8'hEE, 1'b1, 1'b1);
        end
        mk = hit_mask(cap_m[23:0]);
        chk("t6_mask",   mk, hit_mask(24'hEEEEEE));
        chk("t6_hits",   32'($countones(mk)), 32'd5);
        chk("t6_nvalid", 32'(n_valid), 32'd24);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic v, s;
            logic [W-1:0] d;
            v = 1'($urandom_range(0, 1));
            d = W'($urandom);
            s = ($urandom_range(0, 3) != 0);
            cycle(v, d, s, 1'b1);
        end
        repeat (30) cycle(1'b0, '0, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
